run_sequencer: RTL



---
 rtl/run_seq_pkg.sv | 30 +++
 rtl/hold_channel.sv | 43 ++++
 rtl/run_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/run_seq_pkg.sv
// Shared types and helpers for run_sequencer and its hold channels.
package run_seq_pkg;

    localparam int unsigned DEF_DW         = 8;
    localparam int unsigned MAX_DELAY_BITS = 1024;

    typedef enum logic [1:0] {
        SEQ  = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Largest of `channels` unsigned fields of `dw` bits packed LSB-first in `delays`.
    function automatic int unsigned dly_max(input logic [MAX_DELAY_BITS-1:0] delays,
                                            input int unsigned channels,
                                            input int unsigned dw);
        int unsigned v_max;
        int unsigned v_cur;
        v_max = 0;
        for (int unsigned i = 0; i < channels; i++) begin
            v_cur = 0;
            for (int unsigned b = 0; b < dw; b++) begin
                if (delays[10'(i * dw + b)]) v_cur = v_cur | (32'd1 << b);
            end
            if (v_cur > v_max) v_max = v_cur;
        end
        return v_max;
    endfunction

endpackage

// File: rtl/hold_channel.sv
// One hold line: released once the release sequence reaches its delay, re-armed by
// restart, and driven to its DONE_MASK bit when the run budget expires.
module hold_channel
    import run_seq_pkg::*;
#(
    parameter int unsigned DW = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] i_seq_cnt,
    input  state_t        i_state,
    input  logic          i_restart,
    input  logic          i_expire,
    input  logic [DW-1:0] i_delay,
    input  logic          i_done_mask,
    output logic          o_hold
);

    localparam int unsigned SW = DW + 1;

    logic          r_hold;
    logic          w_reached;

    // Edge about to occur is edge seq_cnt+1; a zero delay still releases on edge 1.
    assign w_reached = (SW'(i_seq_cnt) + SW'(1)) >= SW'(i_delay);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold <= 1'b1;
        end else if (i_restart) begin
            r_hold <= 1'b1;
        end else begin
            case (i_state)
                SEQ:     if (w_reached) r_hold <= 1'b0;
                RUN:     if (i_expire)  r_hold <= i_done_mask;
                default: ;
            endcase
        end
    end

    assign o_hold = r_hold;

endmodule

// File: rtl/run_sequencer.sv
// Staged hold release, cycle-budgeted RUN and sticky DONE around the core.
// Define RUN_SEQUENCER_STATS_EN to expose the cycle and retired-instruction counters.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int unsigned            CHANNELS  = 2,
    parameter int unsigned            DW        = DEF_DW,
    parameter logic [CHANNELS*DW-1:0] DELAYS    = {8'd4, 8'd3},
    parameter logic [CHANNELS-1:0]    DONE_MASK = 2'b10,
    parameter int unsigned            CNTW      = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                restart,
    input  logic [CNTW-1:0]     budget,
    input  logic                retire,
    output logic [CHANNELS-1:0] hold_out,
    output logic                running,
    output logic                done,
    output logic [CNTW-1:0]     clk_count,
    output logic [CNTW-1:0]     insn_count
);

    localparam int unsigned DLY_MAX  = dly_max(MAX_DELAY_BITS'(DELAYS), CHANNELS, DW);
    localparam int unsigned RUN_EDGE = (DLY_MAX > 0) ? DLY_MAX : 1;
    localparam int unsigned SW       = DW + 1;

    state_t          r_state;
    logic [DW-1:0]   r_seq_cnt;
    logic [CNTW-1:0] r_budget_q;
    logic [CNTW-1:0] r_clk_cnt;
    logic            r_running;
    logic            r_done;

    logic [SW-1:0]   w_seq_inc;
    logic [DW-1:0]   w_seq_sat;
    logic            w_seq_last;
    logic            w_expire;

    assign w_seq_inc  = SW'(r_seq_cnt) + SW'(1);
    assign w_seq_sat  = (w_seq_inc > SW'(DLY_MAX)) ? DW'(DLY_MAX) : w_seq_inc[DW-1:0];
    assign w_seq_last = w_seq_inc >= SW'(RUN_EDGE);
    // Last RUN cycle of a non-zero budget; the cycle counter lands on budget_q.
    assign w_expire   = (r_state == RUN) && (r_budget_q != '0)
                        && ((r_clk_cnt + CNTW'(1)) == r_budget_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= SEQ;
            r_seq_cnt  <= '0;
            r_budget_q <= '0;
            r_clk_cnt  <= '0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
        end else if (restart) begin
            r_state    <= SEQ;
            r_seq_cnt  <= '0;
            r_clk_cnt  <= '0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                SEQ: begin
                    r_seq_cnt <= w_seq_sat;
                    if (w_seq_last) begin
                        r_state    <= RUN;
                        r_running  <= 1'b1;
                        r_budget_q <= budget;
                    end
                end
                RUN: begin
                    if (r_clk_cnt != '1) r_clk_cnt <= r_clk_cnt + CNTW'(1);
                    if (w_expire) begin
                        r_state   <= DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_hold
        hold_channel #(
            .DW(DW)
        ) u_hold (
            .clk         (clk),
            .reset       (reset),
            .i_seq_cnt   (r_seq_cnt),
            .i_state     (r_state),
            .i_restart   (restart),
            .i_expire    (w_expire),
            .i_delay     (DELAYS[g*DW +: DW]),
            .i_done_mask (DONE_MASK[g]),
            .o_hold      (hold_out[g])
        );
    end

    assign running = r_running;
    assign done    = r_done;

`ifdef RUN_SEQUENCER_STATS_EN
    logic [CNTW-1:0] r_insn_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_insn_cnt <= '0;
        end else if (restart) begin
            r_insn_cnt <= '0;
        end else if ((r_state == RUN) && retire && (r_insn_cnt != '1)) begin
            r_insn_cnt <= r_insn_cnt + CNTW'(1);
        end
    end

    assign clk_count  = r_clk_cnt;
    assign insn_count = r_insn_cnt;
`else
    logic w_unused_retire;
    assign w_unused_retire = retire;

    assign clk_count  = '0;
    assign insn_count = '0;
`endif

endmodule
